// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_reg_slave
// Function : AXI4-Lite responder for NUM_REGS byte-strobed 32-bit registers
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int              c_iw       = ADDR_WIDTH - 2;
  localparam int              c_nb       = DATA_WIDTH / 8;
  localparam logic [c_iw:0]   c_num_regs = (c_iw + 1)'(NUM_REGS);
  localparam logic [1:0]      c_okay     = 2'b00;
  localparam logic [1:0]      c_decerr   = 2'b11;

  logic                           r_rst_done;
  logic                           r_aw_hold;
  logic                           r_w_hold;
  logic [c_iw-1:0]                r_aw_idx;
  logic [DATA_WIDTH-1:0]          r_w_data;
  logic [c_nb-1:0]                r_w_strb;
  logic                           r_bvalid;
  logic [1:0]                     r_bresp;
  logic                           r_rvalid;
  logic [1:0]                     r_rresp;
  logic [DATA_WIDTH-1:0]          r_rdata;
  logic [NUM_REGS*DATA_WIDTH-1:0] r_regs;
  logic [NUM_REGS-1:0]            r_wr_pulse;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [c_iw-1:0]       w_wr_idx;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [c_nb-1:0]       w_wr_strb;
  logic                  w_wr_in_range;
  logic [NUM_REGS-1:0]   w_wr_sel;
  logic [c_iw-1:0]       w_rd_idx;
  logic                  w_rd_in_range;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_unused;

  // Readies depend on registered state only, never on an incoming valid.
  assign awready = r_rst_done & ~r_aw_hold & ~r_bvalid;
  assign wready  = r_rst_done & ~r_w_hold & ~r_bvalid;
  assign arready = r_rst_done & ~r_rvalid;

  assign w_aw_hs  = awvalid & awready;
  assign w_w_hs   = wvalid & wready;
  assign w_ar_hs  = arvalid & arready;
  assign w_commit = (r_aw_hold | w_aw_hs) & (r_w_hold | w_w_hs);

  assign w_wr_idx      = r_aw_hold ? r_aw_idx : awaddr[ADDR_WIDTH-1:2];
  assign w_wr_data     = r_w_hold ? r_w_data : wdata;
  assign w_wr_strb     = r_w_hold ? r_w_strb : wstrb;
  assign w_wr_in_range = {1'b0, w_wr_idx} < c_num_regs;

  assign w_rd_idx      = araddr[ADDR_WIDTH-1:2];
  assign w_rd_in_range = {1'b0, w_rd_idx} < c_num_regs;

  assign w_unused = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_wr_sel
      assign w_wr_sel[i] = w_commit & w_wr_in_range & (w_wr_idx == c_iw'(i));
    end
  endgenerate

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_idx == c_iw'(i)) w_rd_data = r_regs[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rst_done <= 1'b0;
    else          r_rst_done <= 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int k = 0; k < c_nb; k++) begin
          if (w_wr_sel[i] && w_wr_strb[k])
            r_regs[DATA_WIDTH*i + 8*k +: 8] <= w_wr_data[8*k +: 8];
        end
      end
    end
  end

  // Write channel: hold whichever of AW/W arrives first until its partner shows up.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_hold  <= 1'b0;
      r_w_hold   <= 1'b0;
      r_aw_idx   <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= c_okay;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= w_wr_sel;
      if (w_commit) begin
        r_aw_hold <= 1'b0;
        r_w_hold  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_in_range ? c_okay : c_decerr;
      end else begin
        if (w_aw_hs) begin
          r_aw_hold <= 1'b1;
          r_aw_idx  <= awaddr[ADDR_WIDTH-1:2];
        end
        if (w_w_hs) begin
          r_w_hold <= 1'b1;
          r_w_data <= wdata;
          r_w_strb <= wstrb;
        end
        if (r_bvalid && bready) begin
          r_bvalid <= 1'b0;
          r_bresp  <= c_okay;
        end
      end
    end
  end

  // Read samples r_regs before any same-edge write lands, returning the old value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rvalid <= 1'b0;
      r_rresp  <= c_okay;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_rd_in_range ? c_okay : c_decerr;
      r_rdata  <= w_rd_in_range ? w_rd_data : '0;
    end else if (r_rvalid && rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign bvalid       = r_bvalid;
  assign bresp        = r_bresp;
  assign rvalid       = r_rvalid;
  assign rresp        = r_rresp;
  assign rdata        = r_rdata;
  assign reg_out      = r_regs;
  assign reg_wr_pulse = r_wr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_reg_slave
// Function : Directed and randomized self-checking bench for axi_lite_reg_slave
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_reg_slave;

  localparam int c_nregs = 8;

  logic                    aclk = 1'b0;
  logic                    aresetn = 1'b0;
  logic [31:0]             awaddr = '0;
  logic [2:0]              awprot = '0;
  logic                    awvalid = 1'b0;
  logic                    awready;
  logic [31:0]             wdata = '0;
  logic [3:0]              wstrb = '0;
  logic                    wvalid = 1'b0;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready = 1'b0;
  logic [31:0]             araddr = '0;
  logic [2:0]              arprot = '0;
  logic                    arvalid = 1'b0;
  logic                    arready;
  logic [31:0]             rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready = 1'b0;
  logic [c_nregs*32-1:0]   reg_out;
  logic [c_nregs-1:0]      reg_wr_pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_regs [c_nregs];

  axi_lite_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(c_nregs)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_packed();
    logic [255:0] v = '0;
    for (int i = 0; i < c_nregs; i++) v[32*i +: 32] = model_regs[i];
    return v;
  endfunction

  function automatic bit in_range(input logic [31:0] addr);
    return (addr / 4) < c_nregs;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    logic [31:0] mask = 0;
    if (!in_range(addr)) return;
    for (int k = 0; k < 4; k++) if (strb[k]) mask = mask + (32'hFF << (8 * k));
    model_regs[addr / 4] = (model_regs[addr / 4] & ~mask) | (data & mask);
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int bwait);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int cyc = 0;
    logic [1:0] exp_resp;
    logic [7:0] exp_pulse;
    while (!(aw_done && w_done) && cyc < 100) begin
      if (!aw_done && cyc >= aw_dly) begin awvalid = 1'b1; awaddr = addr; end
      if (!w_done && cyc >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
      @(negedge aclk);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      if (w_done && !aw_done) check("wready_while_w_held", wready, 1'b0);
      if (aw_done && !w_done) check("awready_while_aw_held", awready, 1'b0);
      @(posedge aclk); #1;
      if (hs_aw) begin aw_done = 1; awvalid = 1'b0; end
      if (hs_w)  begin w_done = 1;  wvalid = 1'b0; end
      if (!(aw_done && w_done)) check("bvalid_before_commit", bvalid, 1'b0);
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("write_handshake_timeout", aw_done && w_done, 1'b1);
    exp_resp  = in_range(addr) ? 2'b00 : 2'b11;
    exp_pulse = in_range(addr) ? (8'd1 << (addr / 4)) : 8'd0;
    model_write(addr, data, strb);
    check("bvalid_after_commit", bvalid, 1'b1);
    check("bresp", bresp, exp_resp);
    check("reg_wr_pulse", reg_wr_pulse, exp_pulse);
    check("reg_out_after_write", reg_out, model_packed());
    for (int c = 0; c < bwait; c++) begin
      @(posedge aclk); #1;
      check("bvalid_stable", bvalid, 1'b1);
      check("bresp_stable", bresp, exp_resp);
      check("aw_w_ready_blocked", {awready, wready}, 2'b00);
      check("pulse_one_cycle", reg_wr_pulse, 8'd0);
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    check("bvalid_cleared", bvalid, 1'b0);
    check("pulse_cleared", reg_wr_pulse, 8'd0);
    check("aw_w_ready_back", {awready, wready}, 2'b11);
  endtask

  task automatic do_read(input logic [31:0] addr, input int rwait);
    bit done = 0, hs;
    int cyc = 0;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    exp_data = in_range(addr) ? model_regs[addr / 4] : 32'h0;
    exp_resp = in_range(addr) ? 2'b00 : 2'b11;
    arvalid = 1'b1; araddr = addr;
    while (!done && cyc < 100) begin
      @(negedge aclk);
      hs = arvalid && arready;
      @(posedge aclk); #1;
      if (hs) done = 1;
      cyc++;
    end
    arvalid = 1'b0;
    check("read_handshake_timeout", done, 1'b1);
    check("rvalid_after_ar", rvalid, 1'b1);
    check("rdata", rdata, exp_data);
    check("rresp", rresp, exp_resp);
    for (int c = 0; c < rwait; c++) begin
      @(posedge aclk); #1;
      check("rvalid_stable", rvalid, 1'b1);
      check("rdata_stable", rdata, exp_data);
      check("rresp_stable", rresp, exp_resp);
      check("arready_blocked", arready, 1'b0);
    end
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
    check("rvalid_cleared", rvalid, 1'b0);
    check("arready_back", arready, 1'b1);
  endtask

  initial begin
    logic [31:0] old_val, a, d;
    for (int i = 0; i < c_nregs; i++) model_regs[i] = 32'h0;

    // Reset state and release
    repeat (2) @(posedge aclk);
    #1;
    check("rst_readies", {awready, wready, arready}, 3'b000);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_reg_out", reg_out, model_packed());
    check("rst_pulse", reg_wr_pulse, 8'd0);
    #2 aresetn = 1'b1;
    #1 check("readies_before_first_edge", {awready, wready, arready}, 3'b000);
    @(posedge aclk); #1;
    check("readies_after_first_edge", {awready, wready, arready}, 3'b111);

    // Write/readback, split channels, strobes, decode error
    do_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h8, 0);
    do_write(32'h4, 32'h11223344, 4'hF, 3, 0, 0);
    do_read(32'h4, 0);
    do_write(32'hC, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(32'hC, 32'h00000000, 4'h5, 0, 0, 0);
    check("strobe_reg3", reg_out[3*32 +: 32], 32'hFF00FF00);
    do_write(32'h10, 32'hCAFEF00D, 4'h0, 0, 1, 0);
    do_write(32'h20, 32'h12345678, 4'hF, 0, 0, 0);
    do_read(32'h20, 0);

    // Backpressure on both response channels
    do_write(32'h1C, 32'hA5A55A5A, 4'hF, 1, 0, 10);
    do_read(32'h1C, 10);

    // Same-edge commit and read of one register returns the pre-write value
    do_write(32'h14, 32'h0BADF00D, 4'hF, 0, 0, 0);
    wvalid = 1'b1; wdata = 32'h600DCAFE; wstrb = 4'hF;
    @(negedge aclk) check("pre_wready", wready, 1'b1);
    @(posedge aclk); #1;
    wvalid = 1'b0;
    awvalid = 1'b1; awaddr = 32'h14; arvalid = 1'b1; araddr = 32'h14;
    @(negedge aclk) check("pre_aw_ar_ready", {awready, arready}, 2'b11);
    @(posedge aclk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    old_val = model_regs[5];
    model_write(32'h14, 32'h600DCAFE, 4'hF);
    check("same_edge_rdata_old", rdata, old_val);
    check("same_edge_valids", {bvalid, rvalid}, 2'b11);
    check("same_edge_reg_out", reg_out, model_packed());
    bready = 1'b1; rready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0; rready = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 9) * 4) + $urandom_range(0, 3);
      d = $urandom;
      if ($urandom_range(0, 2) != 0)
        do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2));
    end

    // Reset while an AW is held and a read response is pending
    awvalid = 1'b1; awaddr = 32'h0; arvalid = 1'b1; araddr = 32'h8;
    @(posedge aclk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    check("pre_reset_aw_held", {awready, wready}, 2'b01);
    check("pre_reset_rvalid", rvalid, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    for (int i = 0; i < c_nregs; i++) model_regs[i] = 32'h0;
    check("mid_reset_valids", {bvalid, rvalid}, 2'b00);
    check("mid_reset_reg_out", reg_out, model_packed());
    check("mid_reset_readies", {awready, wready, arready}, 3'b000);
    @(posedge aclk); #3;
    aresetn = 1'b1;
    #1 check("post_reset_readies_low", {awready, wready, arready}, 3'b000);
    @(posedge aclk); #1;
    check("post_reset_readies_high", {awready, wready, arready}, 3'b111);
    do_write(32'h18, 32'h13579BDF, 4'hF, 0, 2, 0);
    do_read(32'h18, 0);
    do_read(32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
